// File: rtl/key_debounce.sv
// Eight-key debouncer: two-flop synchronizer, per-key stable-run counter, and
// registered chord / lowest-key note / press strobe / any-key outputs.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] keys,
  output logic [7:0] chord,
  output logic [7:0] note,
  output logic [7:0] press_strobe,
  output logic       any_key
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1, sync2;
  logic [7:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  // Any return of sync2 to the stable level drops the partial count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync2[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Side outputs come from stable_d so they change on the same edge as chord.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1        <= '0;
      sync2        <= '0;
      stable_q     <= '0;
      note         <= '0;
      press_strobe <= '0;
      any_key      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1        <= keys;
      sync2        <= sync1;
      stable_q     <= stable_d;
      note         <= stable_d & (~stable_d + 8'd1);
      press_strobe <= stable_d & ~stable_q;
      any_key      <= |stable_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign chord = stable_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=4: table vectors and hand sequences feed a
// scoreboard queue of expected outputs keyed by clock-edge number.
module tb_key_debounce;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] keys   = 8'h00;
  logic [7:0] chord, note, press_strobe;
  logic       any_key;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .keys        (keys),
    .chord       (chord),
    .note        (note),
    .press_strobe(press_strobe),
    .any_key     (any_key)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        drive;
    logic [7:0]  k;
    int unsigned at;
    logic [7:0]  c;
    logic [7:0]  n;
    logic [7:0]  s;
    logic        a;
  } vec_t;

  typedef struct {
    int unsigned at;
    logic [7:0]  c;
    logic [7:0]  n;
    logic [7:0]  s;
    logic        a;
    int          id;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          scount[8];
  vec_t        tbl[16];

  always @(posedge clk_in) cyc <= cyc + 1;

  initial for (int i = 0; i < 8; i++) scount[i] = 0;
  always begin
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 8; i++) if (press_strobe[i]) scount[i] = scount[i] + 1;
  end

  // Entries are pushed in edge order; anything older than the current edge was missed.
  always @(negedge clk_in) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      sb_e = sb.pop_front();
      n_checks++;
      if (sb_e.at != cyc) begin
        n_fail++;
        $display("FAIL id%0d missed check at cyc %0d (now %0d)", sb_e.id, sb_e.at, cyc);
      end else if (chord !== sb_e.c || note !== sb_e.n || press_strobe !== sb_e.s ||
                   any_key !== sb_e.a) begin
        n_fail++;
        $display("FAIL id%0d cyc %0d got chord=%h note=%h strobe=%h any=%b want %h %h %h %b",
                 sb_e.id, cyc, chord, note, press_strobe, any_key,
                 sb_e.c, sb_e.n, sb_e.s, sb_e.a);
      end
    end
  end

  task automatic push(input int unsigned at, input logic [7:0] c, input logic [7:0] n,
                      input logic [7:0] s, input logic a, input int id);
    exp_t e;
    e.at = at; e.c = c; e.n = n; e.s = s; e.a = a; e.id = id;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk_in);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain timeout: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_direct(input string name, input logic [7:0] c, input logic [7:0] n,
                              input logic [7:0] s, input logic a);
    n_checks++;
    if (chord !== c || note !== n || press_strobe !== s || any_key !== a) begin
      n_fail++;
      $display("FAIL %s got chord=%h note=%h strobe=%h any=%b want %h %h %h %b",
               name, chord, note, press_strobe, any_key, c, n, s, a);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Drive at a negedge, then release to zero and wait for the release to settle.
  task automatic release_all(input int id);
    drain();
    keys = 8'h00;
    push(cyc + 1 + 5, 8'h00, 8'h00, 8'h00, 1'b0, id);
    drain();
  endtask

  initial begin
    int unsigned base;
    int          snap;

    //            drive keys   at  chord  note   strobe any
    tbl[0]  = '{1'b1, 8'h00, 0,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h01, 4,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h01, 5,  8'h01, 8'h01, 8'h01, 1'b1};
    tbl[3]  = '{1'b0, 8'h01, 6,  8'h01, 8'h01, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 8'h01, 20, 8'h01, 8'h01, 8'h00, 1'b1};
    tbl[5]  = '{1'b1, 8'h00, 4,  8'h01, 8'h01, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 5,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 6,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h90, 5,  8'h90, 8'h10, 8'h90, 1'b1};
    tbl[9]  = '{1'b0, 8'h90, 6,  8'h90, 8'h10, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 8'h94, 4,  8'h90, 8'h10, 8'h00, 1'b1};
    tbl[11] = '{1'b0, 8'h94, 5,  8'h94, 8'h04, 8'h04, 1'b1};
    tbl[12] = '{1'b0, 8'h94, 6,  8'h94, 8'h04, 8'h00, 1'b1};
    tbl[13] = '{1'b1, 8'h14, 5,  8'h14, 8'h04, 8'h00, 1'b1};
    tbl[14] = '{1'b1, 8'h10, 5,  8'h10, 8'h10, 8'h00, 1'b1};
    tbl[15] = '{1'b1, 8'h00, 5,  8'h00, 8'h00, 8'h00, 1'b0};

    keys = 8'hFF;
    repeat (3) @(negedge clk_in);
    check_direct("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    keys = 8'h00;
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);

    base = cyc;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].drive) begin
        if (sb.size() != 0) drain();
        keys = tbl[i].k;
        base = cyc;
      end
      push(base + 1 + tbl[i].at, tbl[i].c, tbl[i].n, tbl[i].s, tbl[i].a, i);
    end
    drain();

    // Bounce on Mi4: 3 high, 1 low, then held; the count restarts at the final rise.
    snap = scount[2];
    base = cyc;
    push(base + 1 + 8,  8'h00, 8'h00, 8'h00, 1'b0, 100);
    push(base + 1 + 9,  8'h04, 8'h04, 8'h04, 1'b1, 101);
    push(base + 1 + 10, 8'h04, 8'h04, 8'h00, 1'b1, 102);
    for (int k = 0; k < 14; k++) begin
      keys = (k == 3) ? 8'h00 : 8'h04;
      @(negedge clk_in);
    end
    drain();
    check_int("bounce_strobe_count", scount[2] - snap, 1);
    release_all(103);

    // Two keys started two cycles apart finish on their own schedules.
    base = cyc;
    push(base + 1 + 4, 8'h00, 8'h00, 8'h00, 1'b0, 110);
    push(base + 1 + 5, 8'h08, 8'h08, 8'h08, 1'b1, 111);
    push(base + 1 + 6, 8'h08, 8'h08, 8'h00, 1'b1, 112);
    push(base + 1 + 7, 8'h28, 8'h08, 8'h20, 1'b1, 113);
    push(base + 1 + 8, 8'h28, 8'h08, 8'h00, 1'b1, 114);
    for (int k = 0; k < 10; k++) begin
      keys = (k < 2) ? 8'h08 : 8'h28;
      @(negedge clk_in);
    end
    drain();
    release_all(115);

    // All keys at once, then a reset while they are held: fresh debounce and strobe.
    keys = 8'hFF;
    base = cyc;
    push(base + 1 + 4, 8'h00, 8'h00, 8'h00, 1'b0, 200);
    push(base + 1 + 5, 8'hFF, 8'h01, 8'hFF, 1'b1, 201);
    push(base + 1 + 6, 8'hFF, 8'h01, 8'h00, 1'b1, 202);
    drain();
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1 check_direct("async_reset_held", 8'h00, 8'h00, 8'h00, 1'b0);
    #4 rst = 1'b0;
    base = cyc;
    push(base + 1, 8'h00, 8'h00, 8'h00, 1'b0, 203);
    push(base + 5, 8'h00, 8'h00, 8'h00, 1'b0, 204);
    push(base + 6, 8'hFF, 8'h01, 8'hFF, 1'b1, 205);
    push(base + 7, 8'hFF, 8'h01, 8'h00, 1'b1, 206);
    drain();
    release_all(207);

    // Reset pulsed between edges 2 and 3 while Do5 is mid-count.
    keys = 8'h80;
    base = cyc;
    push(base + 1 + 1, 8'h00, 8'h00, 8'h00, 1'b0, 300);
    push(base + 1 + 3, 8'h00, 8'h00, 8'h00, 1'b0, 301);
    push(base + 1 + 7, 8'h00, 8'h00, 8'h00, 1'b0, 302);
    push(base + 1 + 8, 8'h80, 8'h80, 8'h80, 1'b1, 303);
    push(base + 1 + 9, 8'h80, 8'h80, 8'h00, 1'b1, 304);
    repeat (3) @(posedge clk_in);
    #2 rst = 1'b1;
    #1 check_direct("async_reset_midcount", 8'h00, 8'h00, 8'h00, 1'b0);
    #4 rst = 1'b0;
    drain();
    release_all(305);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable clock cycles required to accept a key change (20 ms at 50 MHz); legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 20, meaning the width of each per-key debounce counter.
REQ-003 SHALL have port clk_in, input, 1 bit: single system clock, 50 MHz; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port keys, input, 8 bits: raw asynchronous piano buttons, active-high; bit0=Do4, bit1=Re4, bit2=Mi4, bit3=Fa4, bit4=Sol4, bit5=La4, bit6=Si4, bit7=Do5.
REQ-006 SHALL have port chord, output, 8 bits: registered debounced key levels, same bit order; feeds the frequency divider chord input.
REQ-007 SHALL have port note, output, 8 bits: registered one-hot of the lowest-index set bit of chord, or all-zero when no key is held.
REQ-008 SHALL have port press_strobe, output, 8 bits: registered, one-cycle pulse per key on each debounced 0->1 transition.
REQ-009 SHALL have port any_key, output, 1 bit: registered OR of chord.

Function
REQ-010 SHALL pass each keys bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL keep, per key, a stable bit (drives chord) and a CNT_W-bit counter.
REQ-012 Per key, when sync2 equals stable, the counter SHALL be cleared to 0 on that edge.
REQ-013 Per key, when sync2 differs from stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 Per key, when sync2 differs from stable and counter == DEBOUNCE_CYCLES-1, stable SHALL take sync2 and the counter SHALL clear to 0 on that edge.
REQ-015 Latency: a raw change first sampled at edge 0 and held SHALL appear on chord after edge DEBOUNCE_CYCLES+1; with DEBOUNCE_CYCLES=1 this is edge 2.
REQ-016 A bounce, where sync2 returns to stable before the count completes, SHALL discard the partial count; the next differing run starts from 0.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-018 Keys SHALL be debounced independently; simultaneous changes on several keys SHALL each complete on their own schedule, with no interaction.
REQ-019 note, press_strobe and any_key SHALL be computed from the next-state stable vector and update on the same edge as chord; there is no extra cycle of latency.
REQ-020 note priority SHALL be lowest index first. Example: chord=8'b1001_0100 -> note=8'b0000_0100.
REQ-021 press_strobe[i] SHALL be high for exactly one cycle on the edge where stable[i] goes 0->1, and SHALL stay low on 1->0 transitions.
REQ-022 A key held indefinitely SHALL produce exactly one press_strobe pulse.

Reset
REQ-023 While rst is high, all of the following SHALL be 0 immediately, with no clock required: sync1, sync2, stable, counters, chord, note, press_strobe and any_key.
REQ-024 Reset asserted mid-count SHALL discard the count. After release, a key still held SHALL be re-debounced from 0 and SHALL produce a fresh press_strobe.
REQ-025 On the first edge after rst falls, there SHALL be no spurious strobe or chord change.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean press: keys=8'h01 from edge 0 -> chord=8'h01, note=8'h01, press_strobe=8'h01 and any_key=1 after edge 5; press_strobe=0 after edge 6.
REQ-027 Bounce: keys[2] high for 3 cycles, low for 1, then high and held -> chord[2] stays 0 through the bounce and becomes 1 exactly 4 stable cycles (plus sync) after the final rise; exactly one strobe.
REQ-028 Chord priority: keys=8'h90 held, then keys=8'h94 -> note=8'h10, then note=8'h04 after the Mi4 debounce; chord=8'h94.
REQ-029 Release: keys from 8'h01 to 8'h00 held -> chord=8'h00, note=8'h00 and any_key=0 after edge 5 from the change; no press_strobe.
REQ-030 Reset mid-count: keys=8'h80, rst pulsed at edge 2 asynchronously between edges -> outputs 0 at once; chord=8'h80 appears 6 edges after release, with one strobe.
REQ-031 Simultaneous: keys=8'hFF at edge 0 -> all eight bits of chord and press_strobe rise on the same edge, and note=8'h01.
